// File: rtl/uart_tx_ctrl.sv
// Transmit-side sequencer for tx_module: owns the write FIFO and the data register,
// and launches one character at a time through the tx_start / tx_busy / tx_done handshake.
module uart_tx_ctrl #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int FIFO_ADDR_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ctrl_en_i,
    input  logic                       fifo_en_i,
    input  logic                       wr_en_i,
    input  logic [MAX_UART_DATA_W-1:0] wr_data_i,
    input  logic                       flush_i,
    input  logic                       ovf_clr_i,
    input  logic                       tx_busy_i,
    input  logic                       tx_done_i,
    output logic                       tx_start_o,
    output logic [MAX_UART_DATA_W-1:0] tx_data_o,
    output logic [FIFO_ADDR_W:0]       fifo_count_o,
    output logic                       fifo_empty_o,
    output logic                       fifo_full_o,
    output logic                       overflow_o,
    output logic                       char_done_o,
    output logic [1:0]                 dbg_state_o
);

    localparam int DEPTH = 2 ** FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W:0]   CNT_ONE = 1;
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [MAX_UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                       char_done_q, char_done_d;
    logic                       mode_q, mode_d;
    logic                       ovf_q, ovf_d;
    logic [FIFO_ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_W:0]       count_q, count_d;
    logic [MAX_UART_DATA_W-1:0] mem_q [DEPTH];

    logic in_idle;
    logic mode_eff;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic ovf_set;

    assign in_idle    = (state_q == ST_IDLE);
    // Mode is live in IDLE and frozen for the rest of a character.
    assign mode_eff   = in_idle ? fifo_en_i : mode_q;
    assign fifo_full  = count_q[FIFO_ADDR_W];
    assign fifo_empty = (count_q == '0);

    // Handshake: tx_start_o is a request held high until tx_busy_i acknowledges it;
    // tx_done_i is a single-cycle completion pulse that ends the character.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        char_done_d = 1'b0;
        pop         = 1'b0;
        mode_d      = mode_eff;
        case (state_q)
            ST_IDLE: begin
                if (fifo_en_i) begin
                    if (ctrl_en_i && !fifo_empty && !flush_i) begin
                        state_d = ST_LOAD;
                    end
                end else if (ctrl_en_i && wr_en_i) begin
                    tx_data_d = wr_data_i;
                    state_d   = ST_START;
                end
            end
            ST_LOAD: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    char_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop in the same cycle frees the head slot, so a push into a full FIFO is accepted.
    always_comb begin
        push    = wr_en_i && mode_eff && !flush_i && (!fifo_full || pop);
        ovf_set = wr_en_i && ((mode_eff && !flush_i && fifo_full && !pop) ||
                              (!mode_eff && !(in_idle && ctrl_en_i)));

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            char_done_q <= 1'b0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            char_done_q <= char_done_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign tx_start_o   = (state_q == ST_START);
    assign tx_data_o    = tx_data_q;
    assign fifo_count_o = count_q;
    assign fifo_empty_o = fifo_empty;
    assign fifo_full_o  = fifo_full;
    assign overflow_o   = ovf_q;
    assign char_done_o  = char_done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: FIFO and single-shot launches, overflow, flush and reset.
module tb_uart_tx_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_en, fifo_en, wr_en, flush, ovf_clr, tx_busy, tx_done;
  logic [7:0] wr_data;
  logic       tx_start, fifo_empty, fifo_full, overflow, char_done;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx_ctrl #(.MAX_UART_DATA_W(8), .FIFO_ADDR_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ctrl_en_i(ctrl_en), .fifo_en_i(fifo_en),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .flush_i(flush), .ovf_clr_i(ovf_clr),
    .tx_busy_i(tx_busy), .tx_done_i(tx_done), .tx_start_o(tx_start),
    .tx_data_o(tx_data), .fifo_count_o(fifo_count), .fifo_empty_o(fifo_empty),
    .fifo_full_o(fifo_full), .overflow_o(overflow), .char_done_o(char_done),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_state", {30'd0, dbg_state}, {30'd0, s});
  endtask

  // tx_module model: acknowledge the start, then one done pulse.
  task automatic complete_char();
    tx_busy = 1'b1;
    cycle();
    chk("cc_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
    chk("cc_start_low", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    chk("cc_char_done", {31'd0, char_done}, 32'd1);
    chk("cc_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
  endtask

  task automatic push_char(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ctrl_en = 1'b1; fifo_en = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    flush = 1'b0; ovf_clr = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    #1;
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_done", {31'd0, char_done}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // FIFO latency: write 0xA5 at N, busy at N+8, done at N+28
    push_char(8'hA5);
    chk("t1_count1", {27'd0, fifo_count}, 32'd1);
    chk("t1_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    cycle();
    chk("t1_load", {30'd0, dbg_state}, {30'd0, S_LOAD});
    chk("t1_nostart", {31'd0, tx_start}, 32'd0);
    cycle();
    chk("t1_start", {31'd0, tx_start}, 32'd1);
    chk("t1_data", {24'd0, tx_data}, 32'hA5);
    chk("t1_count0", {27'd0, fifo_count}, 32'd0);
    for (int k = 4; k <= 8; k++) begin
      cycle();
      chk("t1_start_hold", {31'd0, tx_start}, 32'd1);
    end
    tx_busy = 1'b1;
    cycle();
    chk("t1_start_drop", {31'd0, tx_start}, 32'd0);
    chk("t1_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
    for (int k = 0; k < 19; k++) begin
      cycle();
      chk("t1_no_done", {31'd0, char_done}, 32'd0);
    end
    tx_busy = 1'b0;
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    chk("t1_char_done", {31'd0, char_done}, 32'd1);
    chk("t1_back_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    cycle();
    chk("t1_done_pulse", {31'd0, char_done}, 32'd0);
    chk("t1_data_hold", {24'd0, tx_data}, 32'hA5);

    // 17 back-to-back writes, tx stalled: 0x00 pops, 16 remain
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = i[7:0];
      cycle();
    end
    wr_en = 1'b0;
    chk("t2_count16", {27'd0, fifo_count}, 32'd16);
    chk("t2_full", {31'd0, fifo_full}, 32'd1);
    chk("t2_no_ovf", {31'd0, overflow}, 32'd0);
    chk("t2_data0", {24'd0, tx_data}, 32'h00);
    push_char(8'h20);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_count_hold", {27'd0, fifo_count}, 32'd16);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", {31'd0, overflow}, 32'd0);
    ovf_clr = 1'b1;
    push_char(8'h21);
    ovf_clr = 1'b0;
    chk("t2_ovf_wins", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr2", {31'd0, overflow}, 32'd0);
    chk("t2_still_start", {30'd0, dbg_state}, {30'd0, S_START});

    // full + push + pop in LOAD, then drain across the pointer wrap
    complete_char();
    cycle();
    chk("t3_load", {30'd0, dbg_state}, {30'd0, S_LOAD});
    push_char(8'h11);
    chk("t3_count16", {27'd0, fifo_count}, 32'd16);
    chk("t3_full", {31'd0, fifo_full}, 32'd1);
    chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 1; i <= 17; i++) exp_q.push_back(i[7:0]);
    while (exp_q.size() > 0) begin
      wait_state(S_START, 8);
      chk("t3_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      complete_char();
    end
    cycle();
    chk("t3_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t3_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // single-shot: 0x3C launched, 0x7E in WAIT dropped
    fifo_en = 1'b0;
    push_char(8'h3C);
    chk("t4_start", {31'd0, tx_start}, 32'd1);
    chk("t4_data", {24'd0, tx_data}, 32'h3C);
    tx_busy = 1'b1;
    cycle();
    chk("t4_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
    push_char(8'h7E);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_count0", {27'd0, fifo_count}, 32'd0);
    chk("t4_data_hold", {24'd0, tx_data}, 32'h3C);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    chk("t4_char_done", {31'd0, char_done}, 32'd1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", {31'd0, overflow}, 32'd0);
    ctrl_en = 1'b0;
    push_char(8'h99);
    chk("t4_dis_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_dis_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;

    // flush in LOAD with 3 queued
    fifo_en = 1'b1;
    push_char(8'h61);
    push_char(8'h62);
    push_char(8'h63);
    chk("t5_count3", {27'd0, fifo_count}, 32'd3);
    ctrl_en = 1'b1;
    cycle();
    chk("t5_load", {30'd0, dbg_state}, {30'd0, S_LOAD});
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t5_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("t5_count0", {27'd0, fifo_count}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_start", {31'd0, tx_start}, 32'd0);
      cycle();
    end

    // flush in WAIT: in-flight character completes
    ctrl_en = 1'b0;
    push_char(8'h71);
    push_char(8'h72);
    push_char(8'h73);
    ctrl_en = 1'b1;
    wait_state(S_START, 4);
    chk("t5w_data", {24'd0, tx_data}, 32'h71);
    chk("t5w_count2", {27'd0, fifo_count}, 32'd2);
    tx_busy = 1'b1;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t5w_count0", {27'd0, fifo_count}, 32'd0);
    chk("t5w_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
    tx_busy = 1'b0;
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    chk("t5w_char_done", {31'd0, char_done}, 32'd1);
    cycle();
    chk("t5w_stay_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    push_char(8'h55);
    wait_state(S_START, 4);
    chk("t5w_after_flush", {24'd0, tx_data}, 32'h55);
    complete_char();

    // reset mid-START with 5 queued
    ctrl_en = 1'b0;
    for (int i = 0; i < 6; i++) push_char(8'h81 + i[7:0]);
    ctrl_en = 1'b1;
    wait_state(S_START, 4);
    chk("t6_count5", {27'd0, fifo_count}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_start", {31'd0, tx_start}, 32'd0);
    chk("t6_count", {27'd0, fifo_count}, 32'd0);
    chk("t6_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t6_data", {24'd0, tx_data}, 32'd0);
    chk("t6_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t6_no_start", {31'd0, tx_start}, 32'd0);
      chk("t6_count_after", {27'd0, fifo_count}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
